timer_unit: RTL and testbench
=============================

TIMER_UNIT -- requirements
Module: timer_unit

Interface
REQ-001 SHALL have parameter TCFG_ADDR, default 14'h041, the CSR address of TCFG.
REQ-002 SHALL have parameter TVAL_ADDR, default 14'h042, the CSR address of TVAL (read-only; writes ignored).
REQ-003 SHALL have parameter TICLR_ADDR, default 14'h044, the CSR address of TICLR.
REQ-004 clk  input  1  clock, same domain and edge as the 64-bit stable counter.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 csr_we_i  input  1  CSR write strobe, one write per asserted cycle.
REQ-007 csr_waddr_i  input  14  CSR write address.
REQ-008 csr_wdata_i  input  32  CSR write data.
REQ-009 tcfg_o  output  32  TCFG contents: [0] En, [1] Periodic, [31:2] InitVal.
REQ-010 tval_o  output  32  current countdown value.
REQ-011 timer_int_o  output  1  timer interrupt pending (TI), level, to ESTAT.IS[11].

Function
REQ-012 SHALL implement states IDLE (stopped), RUN (counting) and EXPIRED (one-shot done, stopped).
REQ-013 TCFG write SHALL load tcfg <= wdata and tval <= {wdata[31:2],2'b00} on the next edge, then go to RUN if wdata[0]=1, else IDLE.
REQ-014 In RUN with tval != 0, tval SHALL decrement by 1 each cycle; 32-bit arithmetic, no underflow past 0.
REQ-015 In RUN with tval == 0, TI SHALL be set. Periodic=1: tval reloads {InitVal,2'b00} and the state stays RUN. Periodic=0: tval holds 0 and the state goes to EXPIRED.
REQ-016 Expiry period SHALL be 4*InitVal+1 cycles from the TCFG write edge to the TI-set edge; InitVal=0 expires 1 cycle after enable.
REQ-017 IDLE and EXPIRED SHALL hold tval unchanged and never set TI.
REQ-018 TICLR write with wdata[0]=1 SHALL clear TI on the next edge; wdata[0]=0 has no effect; TICLR does not affect tval or state.
REQ-019 If a TI set and a TICLR clear occur in the same cycle, the set SHALL win and TI = 1.
REQ-020 A TCFG write in the same cycle as an expiry SHALL take priority: tval and state come from the write, and TI is still set.
REQ-021 A TCFG write SHALL NOT clear TI; only TICLR or reset clears it.
REQ-022 Writes to TVAL_ADDR and to unmatched addresses SHALL be ignored.
REQ-023 tcfg_o, tval_o and timer_int_o SHALL be direct register outputs, with no combinational path from the inputs.

Reset
REQ-024 rst_n=0 at a clk edge SHALL force tcfg=0, tval=0, TI=0 and state IDLE, overriding any simultaneous CSR write.
REQ-025 Reset asserted during RUN SHALL abort the countdown; no TI is produced by the aborted period.

Configuration
REQ-026 With TIMER_PERIODIC_EN defined, TCFG[1] SHALL be writable and control reload as in REQ-015.
REQ-027 Without TIMER_PERIODIC_EN, TCFG[1] SHALL be forced to 0 on write and read, the timer SHALL always be one-shot, and no reload logic is built.

Verification
REQ-028 Reset, then write TCFG=32'h0000_0011 (En=1, Periodic=0, InitVal=4) -> tval 16,15,...,0; TI rises 17 cycles after the write edge; state EXPIRED; tval stays 0.
REQ-029 With TIMER_PERIODIC_EN, write TCFG=32'h0000_0007 (InitVal=1, periodic) -> tval 4,3,2,1,0,4,...; TI set every 5 cycles; a TICLR=1 between expiries drops TI for that gap.
REQ-030 Time TICLR=1 to the expiry cycle -> TI remains 1 (set wins).
REQ-031 Run with InitVal=8, then write TCFG=32'h0 mid-count -> tval loads 0, state IDLE, TI unchanged, no further decrement.
REQ-032 Without TIMER_PERIODIC_EN, write TCFG=32'h0000_0007 -> tcfg_o=32'h0000_0005; one-shot expiry after 5 cycles, no reload.
REQ-033 Assert rst_n=0 mid-RUN together with a TCFG write -> next cycle tcfg_o=0, tval_o=0, timer_int_o=0.

Source files
------------

// File: rtl/timer_unit.sv
// CSR-programmed countdown timer with a level interrupt (TI).
// Define TIMER_PERIODIC_EN to build periodic reload; without it, TCFG[1] reads 0 and the timer is one-shot.
module timer_unit #(
  parameter logic [13:0] TCFG_ADDR  = 14'h041,
  parameter logic [13:0] TVAL_ADDR  = 14'h042,
  parameter logic [13:0] TICLR_ADDR = 14'h044
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_we_i,
  input  logic [13:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] tcfg_o,
  output logic [31:0] tval_o,
  output logic        timer_int_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

`ifdef TIMER_PERIODIC_EN
  localparam logic [31:0] TCFG_WMASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] TCFG_WMASK = 32'hFFFF_FFFD;
`endif

  state_t      state_q, state_d;
  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  logic        ti_q, ti_d;
  logic        tcfg_wr, ticlr_wr, expire;

  // Address decode; TVAL is read-only, so a write there falls through like an unmatched address.
  always_comb begin
    tcfg_wr  = 1'b0;
    ticlr_wr = 1'b0;
    case (csr_waddr_i)
      TCFG_ADDR:  tcfg_wr  = csr_we_i;
      TICLR_ADDR: ticlr_wr = csr_we_i;
      TVAL_ADDR:  ;
      default:    ;
    endcase
  end

  assign expire = (state_q == RUN) && (tval_q == 32'd0);

  // Next-state logic: countdown first, then TI set-over-clear, then a TCFG write overrides tval/state.
  always_comb begin
    state_d = state_q;
    tcfg_d  = tcfg_q;
    tval_d  = tval_q;
    ti_d    = ti_q;

    case (state_q)
      RUN: begin
        if (tval_q != 32'd0) begin
          tval_d = tval_q - 32'd1;
        end else begin
`ifdef TIMER_PERIODIC_EN
          if (tcfg_q[1]) begin
            tval_d = {tcfg_q[31:2], 2'b00};
          end else begin
            state_d = EXPIRED;
          end
`else
          state_d = EXPIRED;
`endif
        end
      end
      default: ;
    endcase

    if (ticlr_wr && csr_wdata_i[0]) begin
      ti_d = 1'b0;
    end
    if (expire) begin
      ti_d = 1'b1;
    end

    if (tcfg_wr) begin
      tcfg_d  = csr_wdata_i & TCFG_WMASK;
      tval_d  = {csr_wdata_i[31:2], 2'b00};
      state_d = csr_wdata_i[0] ? RUN : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tcfg_q  <= 32'd0;
      tval_q  <= 32'd0;
      ti_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tcfg_q  <= tcfg_d;
      tval_q  <= tval_d;
      ti_q    <= ti_d;
    end
  end

  assign tcfg_o      = tcfg_q;
  assign tval_o      = tval_q;
  assign timer_int_o = ti_q;

endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit: a vector table plus hand-written countdown/priority sequences,
// with expectations queued as stimulus is driven and compared after each clock edge.
module tb_timer_unit;

  localparam logic [13:0] A_TCFG  = 14'h041;
  localparam logic [13:0] A_TVAL  = 14'h042;
  localparam logic [13:0] A_TICLR = 14'h044;

  logic        clk;
  logic        rst_n;
  logic        csr_we_i;
  logic [13:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] tcfg_o;
  logic [31:0] tval_o;
  logic        timer_int_o;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] tcfg;
    logic [31:0] tval;
    logic        ti;
  } vec_t;

  typedef struct {
    logic [31:0] tcfg;
    logic [31:0] tval;
    logic        ti;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[13];
  int   assert_count = 0;
  int   fail_count   = 0;

  timer_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_we_i    (csr_we_i),
    .csr_waddr_i (csr_waddr_i),
    .csr_wdata_i (csr_wdata_i),
    .tcfg_o      (tcfg_o),
    .tval_o      (tval_o),
    .timer_int_o (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      assert_count++;
      fail_count++;
      $display("[TB] FAIL scoreboard: no expectation queued at %0t", $time);
      return;
    end
    e = exp_q.pop_front();
    assert_count++;
    if (tcfg_o !== e.tcfg) begin
      fail_count++;
      $display("[TB] FAIL %s tcfg: got %h expected %h", e.name, tcfg_o, e.tcfg);
    end
    assert_count++;
    if (tval_o !== e.tval) begin
      fail_count++;
      $display("[TB] FAIL %s tval: got %0d expected %0d", e.name, tval_o, e.tval);
    end
    assert_count++;
    if (timer_int_o !== e.ti) begin
      fail_count++;
      $display("[TB] FAIL %s ti: got %b expected %b", e.name, timer_int_o, e.ti);
    end
  endtask

  // Drive one cycle of inputs, queue the post-edge expectation, then compare after the edge.
  task automatic applyStimulus(input logic r, input logic we, input logic [13:0] addr,
                               input logic [31:0] wdata, input logic [31:0] etcfg,
                               input logic [31:0] etval, input logic eti, input string name);
    exp_t e;
    @(negedge clk);
    rst_n       = r;
    csr_we_i    = we;
    csr_waddr_i = addr;
    csr_wdata_i = wdata;
    e.tcfg = etcfg;
    e.tval = etval;
    e.ti   = eti;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input logic [31:0] etcfg, input logic [31:0] etval, input logic eti,
                      input string name);
    applyStimulus(1'b1, 1'b0, 14'h0, 32'h0, etcfg, etval, eti, name);
  endtask

  initial begin
    rst_n       = 1'b0;
    csr_we_i    = 1'b0;
    csr_waddr_i = 14'h0;
    csr_wdata_i = 32'h0;

    //           rst   we    addr      wdata          tcfg           tval           ti
    vecs[0]  = '{1'b0, 1'b1, A_TCFG,   32'h0000_0011, 32'h0,         32'h0,         1'b0};
    vecs[1]  = '{1'b1, 1'b0, 14'h0,    32'h0,         32'h0,         32'h0,         1'b0};
    vecs[2]  = '{1'b1, 1'b1, A_TVAL,   32'h0000_FFFF, 32'h0,         32'h0,         1'b0};
    vecs[3]  = '{1'b1, 1'b1, 14'h100,  32'h0000_0011, 32'h0,         32'h0,         1'b0};
    vecs[4]  = '{1'b1, 1'b1, A_TCFG,   32'h0000_0010, 32'h0000_0010, 32'd16,        1'b0};
    vecs[5]  = '{1'b1, 1'b0, 14'h0,    32'h0,         32'h0000_0010, 32'd16,        1'b0};
    vecs[6]  = '{1'b1, 1'b1, A_TCFG,   32'h0000_0001, 32'h0000_0001, 32'd0,         1'b0};
    vecs[7]  = '{1'b1, 1'b0, 14'h0,    32'h0,         32'h0000_0001, 32'd0,         1'b1};
    vecs[8]  = '{1'b1, 1'b0, 14'h0,    32'h0,         32'h0000_0001, 32'd0,         1'b1};
    vecs[9]  = '{1'b1, 1'b1, A_TICLR,  32'h0000_0000, 32'h0000_0001, 32'd0,         1'b1};
    vecs[10] = '{1'b1, 1'b1, A_TICLR,  32'h0000_0001, 32'h0000_0001, 32'd0,         1'b0};
    vecs[11] = '{1'b1, 1'b0, 14'h0,    32'h0,         32'h0000_0001, 32'd0,         1'b0};
    vecs[12] = '{1'b1, 1'b1, A_TCFG,   32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].tcfg, vecs[i].tval, vecs[i].ti, $sformatf("vec%0d", i));
    end

    // One-shot InitVal=4: countdown 16..0, TI on the 17th edge, then held at 0.
    applyStimulus(1'b1, 1'b1, A_TCFG, 32'h0000_0011, 32'h11, 32'd16, 1'b0, "oneshot_load");
    for (int k = 1; k <= 16; k++) begin
      idle(32'h11, 32'(16 - k), 1'b0, $sformatf("oneshot_cnt%0d", k));
    end
    idle(32'h11, 32'd0, 1'b1, "oneshot_expire");
    for (int k = 0; k < 3; k++) idle(32'h11, 32'd0, 1'b1, "oneshot_hold");
    applyStimulus(1'b1, 1'b1, A_TICLR, 32'h1, 32'h11, 32'd0, 1'b0, "oneshot_clr");
    for (int k = 0; k < 2; k++) idle(32'h11, 32'd0, 1'b0, "expired_no_ti");

    // TICLR landing on the expiry edge: set wins.
    applyStimulus(1'b1, 1'b1, A_TCFG, 32'h0000_0005, 32'h5, 32'd4, 1'b0, "setwins_load");
    for (int k = 1; k <= 4; k++) idle(32'h5, 32'(4 - k), 1'b0, "setwins_cnt");
    applyStimulus(1'b1, 1'b1, A_TICLR, 32'h1, 32'h5, 32'd0, 1'b1, "setwins_collide");
    applyStimulus(1'b1, 1'b1, A_TICLR, 32'h1, 32'h5, 32'd0, 1'b0, "setwins_clr");

    // TCFG write on the expiry edge: write drives tval/state, TI still set and not cleared by it.
    applyStimulus(1'b1, 1'b1, A_TCFG, 32'h0000_0001, 32'h1, 32'd0, 1'b0, "wrexp_load");
    applyStimulus(1'b1, 1'b1, A_TCFG, 32'h0000_0009, 32'h9, 32'd8, 1'b1, "wrexp_collide");
    idle(32'h9, 32'd7, 1'b1, "wrexp_run");

    // Disable mid-count: tval loads 0, state IDLE, TI untouched, no further decrement.
    applyStimulus(1'b1, 1'b1, A_TCFG, 32'h0000_0021, 32'h21, 32'd32, 1'b1, "stop_load");
    idle(32'h21, 32'd31, 1'b1, "stop_cnt");
    idle(32'h21, 32'd30, 1'b1, "stop_cnt");
    applyStimulus(1'b1, 1'b1, A_TCFG, 32'h0, 32'h0, 32'd0, 1'b1, "stop_write0");
    for (int k = 0; k < 3; k++) idle(32'h0, 32'd0, 1'b1, "stop_idle");
    applyStimulus(1'b1, 1'b1, A_TICLR, 32'h1, 32'h0, 32'd0, 1'b0, "stop_clr");

    // Reset mid-run with a simultaneous TCFG write; aborted period must not raise TI.
    applyStimulus(1'b1, 1'b1, A_TCFG, 32'h0000_0001, 32'h1, 32'd0, 1'b0, "rst_pre");
    idle(32'h1, 32'd0, 1'b1, "rst_pre_ti");
    applyStimulus(1'b1, 1'b1, A_TCFG, 32'h0000_0011, 32'h11, 32'd16, 1'b1, "rst_load");
    idle(32'h11, 32'd15, 1'b1, "rst_cnt");
    idle(32'h11, 32'd14, 1'b1, "rst_cnt");
    applyStimulus(1'b0, 1'b1, A_TCFG, 32'h0000_0011, 32'h0, 32'd0, 1'b0, "rst_with_write");
    for (int k = 0; k < 20; k++) idle(32'h0, 32'd0, 1'b0, "rst_aborted");

`ifdef TIMER_PERIODIC_EN
    // Periodic InitVal=1: 4,3,2,1,0 then reload; TICLR between expiries drops TI.
    applyStimulus(1'b1, 1'b1, A_TCFG, 32'h0000_0007, 32'h7, 32'd4, 1'b0, "per_load");
    for (int k = 1; k <= 4; k++) idle(32'h7, 32'(4 - k), 1'b0, "per_cnt");
    idle(32'h7, 32'd4, 1'b1, "per_expire1");
    applyStimulus(1'b1, 1'b1, A_TICLR, 32'h1, 32'h7, 32'd3, 1'b0, "per_clr");
    for (int k = 2; k <= 4; k++) idle(32'h7, 32'(4 - k), 1'b0, "per_gap");
    idle(32'h7, 32'd4, 1'b1, "per_expire2");
`else
    // One-shot build: Periodic bit reads 0 and there is no reload.
    applyStimulus(1'b1, 1'b1, A_TCFG, 32'h0000_0007, 32'h5, 32'd4, 1'b0, "nop_load");
    for (int k = 1; k <= 4; k++) idle(32'h5, 32'(4 - k), 1'b0, "nop_cnt");
    idle(32'h5, 32'd0, 1'b1, "nop_expire");
    for (int k = 0; k < 3; k++) idle(32'h5, 32'd0, 1'b1, "nop_no_reload");
`endif

    if (exp_q.size() != 0) begin
      assert_count++;
      fail_count++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
